gray_adder_arbiter: RTL and testbench

//   Shares one bit-serial gray_adder (start/done, NOF_BITS serial cycles) among NUM_REQ requesters.
//   Per-requester valid/ready operand channels; round-robin grant; drives adder start and holds operands stable.

---
 rtl/gray_adder_arbiter.sv | 174 +++++++++++++++++
 tb/tb_gray_adder_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_adder_arbiter.sv
// gray_adder_arbiter: shares one bit-serial gray_adder among NUM_REQ requesters.
// A round-robin pick selects one requester at a time. Its operands are held in
// local registers while the adder runs. The sum, or a watchdog error, is returned
// on a single result channel tagged with the requester index.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. req_ready is a one-hot grant that is only offered in IDLE. Once
// res_valid is raised, it stays high with stable res_id/res_sum/res_err until
// res_ready is seen.
module gray_adder_arbiter #(
  parameter int NOF_BITS = 8,
  parameter int NUM_REQ  = 4,
  parameter int TIMEOUT  = 2*NOF_BITS+4,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*NOF_BITS-1:0] req_a,
  input  logic [NUM_REQ*NOF_BITS-1:0] req_b,
  input  logic [NUM_REQ-1:0]          req_pa,
  input  logic [NUM_REQ-1:0]          req_pb,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ID_W-1:0]             res_id,
  output logic [NOF_BITS-1:0]         res_sum,
  output logic                        res_err,
  output logic                        busy,
  output logic                        add_start,
  output logic [NOF_BITS-1:0]         add_a,
  output logic [NOF_BITS-1:0]         add_b,
  output logic                        add_pa,
  output logic                        add_pb,
  input  logic [NOF_BITS-1:0]         add_s,
  input  logic                        add_done
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     id;
  logic [NOF_BITS-1:0] op_a;
  logic [NOF_BITS-1:0] op_b;
  logic                op_pa;
  logic                op_pb;
  logic [WD_W-1:0]     wdog;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W-1:0]     cand;
  logic [NOF_BITS-1:0] sel_a;
  logic [NOF_BITS-1:0] sel_b;
  logic                sel_pa;
  logic                sel_pb;

  // Round-robin search that starts just after the last winner, plus the winner's operand mux.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    sel_a  = '0;
    sel_b  = '0;
    sel_pa = 1'b0;
    sel_pb = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        sel_a  = req_a[i*NOF_BITS +: NOF_BITS];
        sel_b  = req_b[i*NOF_BITS +: NOF_BITS];
        sel_pa = req_pa[i];
        sel_pb = req_pb[i];
      end
    end
  end

  // Grant is offered only in IDLE. It is also held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && win_found) req_ready[win_idx] = 1'b1;
  end

  // The adder always sees the captured operands, so they stay stable for the whole operation.
  always_comb begin
    add_a  = op_a;
    add_b  = op_b;
    add_pa = op_pa;
    add_pb = op_pb;
    res_id = id;
  end

  // Main FSM: accept -> pulse start -> wait for done or watchdog -> present result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_REQ-1);
      id        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_pa     <= 1'b0;
      op_pb     <= 1'b0;
      wdog      <= '0;
      res_sum   <= '0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      add_start <= 1'b0;
    end else begin
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            op_a      <= sel_a;
            op_b      <= sel_b;
            op_pa     <= sel_pa;
            op_pb     <= sel_pb;
            id        <= win_idx;
            ptr       <= win_idx;
            add_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done in the same cycle as the watchdog expiry still wins.
          if (add_done) begin
            res_sum   <= add_s;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= RESP;
          end else if (wdog == WD_W'(TIMEOUT-1)) begin
            res_sum   <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_adder_arbiter.sv
// Bench for gray_adder_arbiter: a behavioural gray_adder stub, a round-robin and
// timing reference model, and a scoreboard that checks every result.
module tb_gray_adder_arbiter;

  localparam int NOF_BITS = 8;
  localparam int NUM_REQ  = 4;
  localparam int TIMEOUT  = 2*NOF_BITS+4;
  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int EW       = 1 + ID_W + NOF_BITS;

  // clock / reset block
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*NOF_BITS-1:0] req_a;
  logic [NUM_REQ*NOF_BITS-1:0] req_b;
  logic [NUM_REQ-1:0]          req_pa;
  logic [NUM_REQ-1:0]          req_pb;
  logic                        res_valid;
  logic                        res_ready;
  logic [ID_W-1:0]             res_id;
  logic [NOF_BITS-1:0]         res_sum;
  logic                        res_err;
  logic                        busy;
  logic                        add_start;
  logic [NOF_BITS-1:0]         add_a;
  logic [NOF_BITS-1:0]         add_b;
  logic                        add_pa;
  logic                        add_pb;
  logic [NOF_BITS-1:0]         add_s    = '0;
  logic                        add_done = 1'b0;

  gray_adder_arbiter #(
    .NOF_BITS(NOF_BITS), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_pa(req_pa), .req_pb(req_pb),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_err(res_err), .busy(busy),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_pa(add_pa), .add_pb(add_pb), .add_s(add_s), .add_done(add_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Gray-code reference arithmetic.
  function automatic logic [NOF_BITS-1:0] g2b(input logic [NOF_BITS-1:0] g);
    logic [NOF_BITS-1:0] b;
    b[NOF_BITS-1] = g[NOF_BITS-1];
    for (int i = NOF_BITS-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [NOF_BITS-1:0] gsum(input logic [NOF_BITS-1:0] a, input logic [NOF_BITS-1:0] b);
    logic [NOF_BITS-1:0] s;
    s = g2b(a) + g2b(b);
    return s ^ (s >> 1);
  endfunction

  // Adder stub: done pulses NOF_BITS+1 cycles after start, unless stub_hang is set.
  int stub_cnt  = 0;
  bit stub_hang = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      stub_cnt <= 0;
      add_done <= 1'b0;
    end else begin
      add_done <= 1'b0;
      if (add_start) begin
        stub_cnt <= NOF_BITS;
        add_s    <= gsum(add_a, add_b);
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1 && !stub_hang) add_done <= 1'b1;
      end
    end
  end

  // scoreboard and reference model
  logic [EW-1:0]       exp_q[$];
  int                  id_log[$];
  int                  grants[NUM_REQ];
  int                  results    = 0;
  bit                  model_idle = 1'b1;
  int                  model_ptr  = NUM_REQ-1;
  int                  start_due  = -1;
  int                  resp_due   = -1;
  int                  win;
  logic [NUM_REQ-1:0]  exp_rdy;
  logic [NOF_BITS-1:0] exp_a, exp_b;
  logic                exp_pa, exp_pb;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_idle = 1'b1;
      model_ptr  = NUM_REQ-1;
      start_due  = -1;
      resp_due   = -1;
    end else begin
      win     = -1;
      exp_rdy = '0;
      if (model_idle) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (win < 0 && req_valid[(model_ptr + k) % NUM_REQ]) win = (model_ptr + k) % NUM_REQ;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, !model_idle);
      chk("add_start", add_start, cyc == start_due);
      if (cyc == start_due) begin
        chk("add_a", add_a, exp_a);
        chk("add_b", add_b, exp_b);
        chk("add_pa", add_pa, exp_pa);
        chk("add_pb", add_pb, exp_pb);
      end
      chk("res_valid", res_valid, !model_idle && resp_due >= 0 && cyc >= resp_due);
      if (res_valid && exp_q.size() > 0) chk("result", {res_err, res_id, res_sum}, exp_q[0]);
      if (res_valid && res_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        id_log.push_back(int'(res_id));
        grants[res_id]++;
        results++;
        model_idle = 1'b1;
      end
      if (win >= 0) begin
        exp_a  = NOF_BITS'(req_a >> (win*NOF_BITS));
        exp_b  = NOF_BITS'(req_b >> (win*NOF_BITS));
        exp_pa = req_pa[win];
        exp_pb = req_pb[win];
        if (stub_hang) exp_q.push_back({1'b1, ID_W'(win), {NOF_BITS{1'b0}}});
        else           exp_q.push_back({1'b0, ID_W'(win), gsum(exp_a, exp_b)});
        model_idle = 1'b0;
        model_ptr  = win;
        start_due  = cyc + 1;
        resp_due   = stub_hang ? cyc + TIMEOUT + 2 : cyc + NOF_BITS + 3;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [NOF_BITS-1:0] a, input logic [NOF_BITS-1:0] b,
                        input logic pa, input logic pb);
    req_a[i*NOF_BITS +: NOF_BITS] = a;
    req_b[i*NOF_BITS +: NOF_BITS] = b;
    req_pa[i] = pa;
    req_pb[i] = pb;
  endtask

  task automatic wait_results(input int target, input int budget);
    int n;
    n = 0;
    while (results < target && n < budget) begin
      step();
      n++;
    end
    chk("result_timeout", results >= target, 1'b1);
  endtask

  int order[5] = '{0, 1, 2, 3, 0};
  int t0, n, base;
  int g0[NUM_REQ];

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_pa    = '0;
    req_pb    = '0;
    res_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) grants[i] = 0;

    // Reset state, with every requester already valid.
    for (int i = 0; i < NUM_REQ; i++)
      set_op(i, NOF_BITS'($urandom), NOF_BITS'($urandom), 1'($urandom), 1'($urandom));
    req_valid = '1;
    repeat (3) step();
    chk("rst_req_ready", req_ready, '0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_add_start", add_start, 1'b0);
    chk("rst_res_sum", res_sum, '0);
    chk("rst_res_err", res_err, 1'b0);
    chk("rst_add_a", add_a, '0);

    // All four requesters valid from reset: expected grant order is 0,1,2,3,0.
    rst_n     = 1'b1;
    res_ready = 1'b1;
    wait_results(5, 200);
    req_valid = '0;
    for (int i = 0; i < 5; i++) chk("grant_order", id_log[i], order[i]);

    // Single op on requester 0 with known operands and latency.
    step();
    set_op(0, 8'h03, 8'h02, 1'b0, 1'b1);
    req_valid = 4'b0001;
    n = 0;
    @(negedge clk);
    while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
    t0 = cyc;
    step();
    req_valid = '0;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    chk("single_latency", cyc - t0, NOF_BITS + 3);
    chk("single_sum", res_sum, 8'h07);
    chk("single_id", res_id, 0);
    chk("single_err", res_err, 1'b0);
    wait_results(6, 50);

    // Consumer stalls for 20 cycles while another requester waits.
    res_ready = 1'b0;
    set_op(2, NOF_BITS'($urandom), NOF_BITS'($urandom), 1'b1, 1'b0);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    n = 0;
    while (!res_valid && n < 50) begin step(); n++; end
    set_op(3, NOF_BITS'($urandom), NOF_BITS'($urandom), 1'b0, 1'b1);
    req_valid = 4'b1000;
    repeat (20) step();
    chk("stall_res_valid", res_valid, 1'b1);
    chk("stall_req_ready", req_ready, '0);
    res_ready = 1'b1;
    wait_results(8, 60);
    req_valid = '0;
    chk("stall_id_2", id_log[6], 2);
    chk("stall_id_3", id_log[7], 3);

    // Hung adder: the watchdog must fire, and the next op must complete normally.
    step();
    stub_hang = 1'b1;
    set_op(1, NOF_BITS'($urandom), NOF_BITS'($urandom), 1'b1, 1'b1);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    wait_results(9, TIMEOUT + 20);
    stub_hang = 1'b0;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    wait_results(10, 50);

    // Asynchronous reset during WAIT.
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (4) step();
    chk("pre_rst_busy", busy, 1'b1);
    req_valid = '1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_res_valid", res_valid, 1'b0);
    chk("async_req_ready", req_ready, '0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    req_valid = '0;
    wait_results(11, 50);
    chk("post_rst_id", id_log[10], 0);

    // Random traffic: 1000 ops with random valids, operands and res_ready.
    for (int i = 0; i < NUM_REQ; i++) g0[i] = grants[i];
    base = results;
    n = 0;
    while (results < base + 1000 && n < 60000) begin
      req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++)
        set_op(i, NOF_BITS'($urandom), NOF_BITS'($urandom), 1'($urandom), 1'($urandom));
      res_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("random_done", results >= base + 1000, 1'b1);
    for (int i = 0; i < NUM_REQ; i++) chk("no_starvation", grants[i] > g0[i], 1'b1);
    req_valid = '0;
    res_ready = 1'b1;
    repeat (30) step();
    chk("drain_queue", exp_q.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
